// File: rtl/cv32e40p_apu_wb_scheduler_if.sv
// APU issue / writeback bundle between the ID-stage issue logic and the
// writeback slot scheduler.
//   master : issue logic side  (drives issue_*, observes ready and wb_*)
//   slave  : scheduler side    (accepts issue_*, drives ready and wb_*)
// Signals:
//   issue_valid  issue request (must not depend on issue_ready)
//   issue_class  op class, stable while issue_valid=1
//   issue_tag    destination tag
//   issue_ready  issue accepted this cycle if valid&ready
//   wb_valid     result retires this cycle (no backpressure)
//   wb_tag       tag of retiring op
//   wb_class     class of retiring op
interface cv32e40p_apu_wb_scheduler_if #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CLS_W = 3
);
  logic             issue_valid;
  logic [CLS_W-1:0] issue_class;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [CLS_W-1:0] wb_class;

  modport master (
    output issue_valid, issue_class, issue_tag,
    input  issue_ready, wb_valid, wb_tag, wb_class
  );

  modport slave (
    input  issue_valid, issue_class, issue_tag,
    output issue_ready, wb_valid, wb_tag, wb_class
  );
endinterface

// File: rtl/cv32e40p_apu_wb_scheduler.sv
// Fixed-latency APU writeback slot scheduler.
// A shift register of D = 2**LW-1 slots models future writeback cycles:
// slot i holds the op that retires i cycles from now. An issue of latency L
// lands in slot L-1 after the shift, so it is refused when slot L is already
// occupied, which guarantees at most one result per cycle.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   apu (slave)     issue handshake and writeback result (see interface)
//   flush_i         drop all in-flight ops, block issue this cycle
//   query_tag_i     tag for RAW hazard lookup
//   query_hit_o     some in-flight op (including the retiring one) matches
//   inflight_cnt_o  number of valid slots
//   busy_o          inflight_cnt_o != 0
module cv32e40p_apu_wb_scheduler #(
  parameter int unsigned             NCLASS    = 6,
  parameter int unsigned             LW        = 3,
  parameter logic [NCLASS*LW-1:0]    LAT_TABLE = {3'd5, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1},
  parameter int unsigned             TAG_W     = 5,
  parameter int unsigned             CLS_W     = $clog2(NCLASS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cv32e40p_apu_wb_scheduler_if.slave   apu,
  input  logic                         flush_i,
  input  logic [TAG_W-1:0]             query_tag_i,
  output logic                         query_hit_o,
  output logic [LW-1:0]                inflight_cnt_o,
  output logic                         busy_o
);

  localparam int unsigned D = (1 << LW) - 1;

  logic [D-1:0]     v_q;
  logic [TAG_W-1:0] tag_q [D];
  logic [CLS_W-1:0] cls_q [D];
  logic [LW-1:0]    cnt_q;

  logic [LW-1:0]    lat;
  logic             slot_busy;
  logic             accept;

  // Latency lookup; out-of-range classes yield 0 and trip the assertion.
  always_comb begin
    lat = '0;
    for (int unsigned i = 0; i < NCLASS; i++) begin
      if (apu.issue_class == CLS_W'(i)) lat = LAT_TABLE[i*LW +: LW];
    end
  end

  // The target slot after the shift is L-1, i.e. slot L now. L == D targets
  // the slot that is refilled empty from the top, so it never conflicts.
  always_comb begin
    slot_busy = 1'b0;
    for (int unsigned i = 1; i < D; i++) begin
      if (lat == LW'(i)) slot_busy = v_q[i];
    end
  end

  assign apu.issue_ready = !flush_i && !slot_busy;
  assign accept          = apu.issue_valid && apu.issue_ready;

  // Reset and flush both empty the pipeline; reset differs only in that it
  // also overrides flush, which is equivalent here.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        tag_q[i] <= '0;
        cls_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < D - 1; i++) begin
        v_q[i]   <= v_q[i+1];
        tag_q[i] <= tag_q[i+1];
        cls_q[i] <= cls_q[i+1];
      end
      v_q[D-1]   <= 1'b0;
      tag_q[D-1] <= '0;
      cls_q[D-1] <= '0;

      if (accept) begin
        for (int unsigned i = 0; i < D; i++) begin
          if (lat == LW'(i + 1)) begin
            v_q[i]   <= 1'b1;
            tag_q[i] <= apu.issue_tag;
            cls_q[i] <= apu.issue_class;
          end
        end
      end

      case ({accept, v_q[0]})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    apu.wb_valid = v_q[0];
    apu.wb_tag   = v_q[0] ? tag_q[0] : '0;
    apu.wb_class = v_q[0] ? cls_q[0] : '0;
  end

  always_comb begin
    query_hit_o = 1'b0;
    for (int unsigned i = 0; i < D; i++) begin
      if (v_q[i] && (tag_q[i] == query_tag_i)) query_hit_o = 1'b1;
    end
  end

  assign inflight_cnt_o = cnt_q;
  assign busy_o         = (cnt_q != '0);

  a_lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
    apu.issue_valid |-> (lat != '0) && (int'(lat) <= int'(D)));

  a_cnt_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    int'(cnt_q) == $countones(v_q));

endmodule

// File: tb/tb_cv32e40p_apu_wb_scheduler.sv
module tb_cv32e40p_apu_wb_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_i;
  logic [4:0] query_tag_i;
  logic       query_hit_o;
  logic [2:0] inflight_cnt_o;
  logic       busy_o;

  cv32e40p_apu_wb_scheduler_if #(.TAG_W(5), .CLS_W(3)) apu ();

  cv32e40p_apu_wb_scheduler #(
    .NCLASS    (6),
    .LW        (3),
    .LAT_TABLE ({3'd5, 3'd4, 3'd2, 3'd1, 3'd1, 3'd1}),
    .TAG_W     (5),
    .CLS_W     (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu            (apu.slave),
    .flush_i        (flush_i),
    .query_tag_i    (query_tag_i),
    .query_hit_o    (query_hit_o),
    .inflight_cnt_o (inflight_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: each in-flight op remembers the absolute cycle in which
  // it retires. Cycle "now" shows every op with retire >= now.
  typedef struct {
    int r;
    int tag;
    int cls;
  } op_t;

  op_t q[$];
  int  now;
  int  lat_of [6] = '{1, 1, 1, 2, 4, 5};
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, now);
  endtask

  // One cycle: drive inputs just after the edge, compare mid-cycle, then
  // advance the model through the coming edge.
  task automatic step(input logic rn, input logic v, input int c, input int t,
                      input logic f, input int qt);
    int e_wbv, e_wbt, e_wbc, e_cnt, e_hit, e_rdy;
    op_t n;
    rst_n           = rn;
    apu.issue_valid = v;
    apu.issue_class = 3'(c);
    apu.issue_tag   = 5'(t);
    flush_i         = f;
    query_tag_i     = 5'(qt);
    #4;
    e_wbv = 0; e_wbt = 0; e_wbc = 0; e_cnt = 0; e_hit = 0;
    e_rdy = f ? 0 : 1;
    foreach (q[i]) begin
      if (q[i].r == now) begin
        e_wbv = 1; e_wbt = q[i].tag; e_wbc = q[i].cls;
      end
      e_cnt++;
      if (q[i].tag == qt) e_hit = 1;
      if (q[i].r == now + lat_of[c]) e_rdy = 0;
    end
    check("issue_ready", int'(apu.issue_ready), e_rdy);
    check("wb_valid",    int'(apu.wb_valid),    e_wbv);
    check("wb_tag",      int'(apu.wb_tag),      e_wbt);
    check("wb_class",    int'(apu.wb_class),    e_wbc);
    check("inflight",    int'(inflight_cnt_o),  e_cnt);
    check("busy",        int'(busy_o),          (e_cnt != 0) ? 1 : 0);
    check("query_hit",   int'(query_hit_o),     e_hit);
    if (!rn || f) begin
      q.delete();
    end else begin
      if (v && e_rdy != 0) begin
        n.r = now + lat_of[c]; n.tag = t; n.cls = c;
        q.push_back(n);
      end
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].r <= now) q.delete(i);
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int qt);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 0, 0, 1'b0, qt);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; query_tag_i = '0;
    apu.issue_valid = 1'b0; apu.issue_class = '0; apu.issue_tag = '0;
    now = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(1, 0);
    check("reset_ready", int'(apu.issue_ready), 1);

    // Reset with slots preloaded; nothing may retire afterwards
    step(1'b1, 1'b1, 5, 4, 1'b0, 4);
    step(1'b1, 1'b1, 3, 5, 1'b0, 4);
    step(1'b1, 1'b1, 0, 6, 1'b0, 4);
    step(1'b0, 1'b1, 1, 8, 1'b0, 4);
    check("post_reset_cnt", int'(inflight_cnt_o), 0);
    idle(7, 4);

    // sqrt tag 7: retires exactly 5 cycles later
    step(1'b1, 1'b1, 5, 7, 1'b0, 7);
    idle(4, 7);
    check("sqrt_wb_tag", int'(apu.wb_tag), 7);
    idle(3, 7);

    // div tag 3, mac blocked two cycles later, accepted one cycle after
    step(1'b1, 1'b1, 4, 3, 1'b0, 3);
    idle(1, 3);
    step(1'b1, 1'b1, 3, 8, 1'b0, 8);
    step(1'b1, 1'b1, 3, 8, 1'b0, 8);
    idle(4, 8);

    // back-to-back addsub
    step(1'b1, 1'b1, 0, 1, 1'b0, 2);
    step(1'b1, 1'b1, 0, 2, 1'b0, 2);
    step(1'b1, 1'b1, 0, 3, 1'b0, 2);
    idle(3, 2);

    // flush with three in flight and a same-cycle issue
    step(1'b1, 1'b1, 5, 11, 1'b0, 11);
    step(1'b1, 1'b1, 5, 12, 1'b0, 12);
    step(1'b1, 1'b1, 5, 13, 1'b0, 13);
    step(1'b1, 1'b1, 0, 14, 1'b1, 13);
    check("flush_cnt", int'(inflight_cnt_o), 0);
    idle(7, 12);

    // hazard lookup on tag 9 through its retire cycle
    step(1'b1, 1'b1, 4, 9, 1'b0, 9);
    idle(6, 9);

    // randomized traffic with occasional flush and reset
    for (int k = 0; k < 600; k++) begin
      logic rn, v, f;
      int c, t, qt;
      rn = ($urandom_range(0, 79) != 0);
      f  = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 2) != 0);
      c  = $urandom_range(0, 5);
      t  = $urandom_range(0, 7);
      if (q.size() != 0 && $urandom_range(0, 1) == 1)
        qt = q[$urandom_range(0, q.size() - 1)].tag;
      else
        qt = $urandom_range(0, 7);
      step(rn, v, c, t, f, qt);
    end
    idle(8, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
